// File: rtl/wb_dest_pipe_pkg.sv
// rtl/wb_dest_pipe_pkg.sv - widths, pipeline register record and rs_ID field helper
package wb_dest_pipe_pkg;

  localparam int REG_LOG = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_RS  = 3;

  typedef struct packed {
    logic [REG_LOG-1:0] rd;
    logic               we;
    logic               ld;
    logic [DATA_W-1:0]  data;
  } dest_t;

  // rs_ID is packed {rs0,rs1,rs2}, so rs0 occupies the most significant field
  function automatic logic [REG_LOG-1:0] rs_sel(input logic [NUM_RS*REG_LOG-1:0] rs, input int idx);
    return rs[(NUM_RS-1-idx)*REG_LOG +: REG_LOG];
  endfunction

endpackage

// File: rtl/wb_dest_pipe_if.sv
// rtl/wb_dest_pipe_if.sv - EX inputs, MEM/WB destination outputs and hazard stall bundle
interface wb_dest_pipe_if;
  import wb_dest_pipe_pkg::*;

  logic [REG_LOG-1:0]        rd_EX;
  logic                      REG_write_EX;
  logic                      MEM_read_EX;
  logic [DATA_W-1:0]         alu_res_EX;
  logic                      flush_EX;
  logic                      stall_MEM;
  logic [DATA_W-1:0]         mem_rdata_MEM;
  logic [NUM_RS*REG_LOG-1:0] rs_ID;
  logic [REG_LOG-1:0]        rd_MEM;
  logic                      REG_write_MEM;
  logic [DATA_W-1:0]         data_MEM;
  logic [REG_LOG-1:0]        rd_WB;
  logic                      REG_write_WB;
  logic [DATA_W-1:0]         data_WB;
  logic                      load_use_stall;

  modport master (
    output rd_EX, REG_write_EX, MEM_read_EX, alu_res_EX, flush_EX, stall_MEM, mem_rdata_MEM, rs_ID,
    input  rd_MEM, REG_write_MEM, data_MEM, rd_WB, REG_write_WB, data_WB, load_use_stall
  );

  modport slave (
    input  rd_EX, REG_write_EX, MEM_read_EX, alu_res_EX, flush_EX, stall_MEM, mem_rdata_MEM, rs_ID,
    output rd_MEM, REG_write_MEM, data_MEM, rd_WB, REG_write_WB, data_WB, load_use_stall
  );

endinterface

// File: rtl/dest_pipe_reg.sv
// rtl/dest_pipe_reg.sv - destination pipeline register with hold and bubble controls
module dest_pipe_reg
  import wb_dest_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  dest_t d,
  output dest_t q
);

  // a bubble only clears the flags; rd/data keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q.we <= 1'b0;
      q.ld <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_dest_pipe.sv
// rtl/wb_dest_pipe.sv - EX/MEM and MEM/WB destination pipeline with load-use hazard detection
module wb_dest_pipe
  import wb_dest_pipe_pkg::*;
(
  input logic           clk,
  input logic           rst,
  wb_dest_pipe_if.slave bus
);

  dest_t ex_d;
  dest_t mem_q;
  dest_t wb_d;
  dest_t wb_q;
  logic  hazard;
  logic  unused_wb_ld;

  always_comb begin
    ex_d.rd   = bus.rd_EX;
    ex_d.we   = bus.REG_write_EX & (|bus.rd_EX) & ~bus.flush_EX;
    ex_d.ld   = bus.MEM_read_EX & ex_d.we;
    ex_d.data = bus.alu_res_EX;
  end

  dest_pipe_reg u_ex_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.stall_MEM),
    .bubble (1'b0),
    .d      (ex_d),
    .q      (mem_q)
  );

  always_comb begin
    wb_d.rd   = mem_q.rd;
    wb_d.we   = mem_q.we;
    wb_d.ld   = 1'b0;
    wb_d.data = mem_q.ld ? bus.mem_rdata_MEM : mem_q.data;
  end

  // a frozen MEM stage must not let WB repeat its write
  dest_pipe_reg u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (1'b0),
    .bubble (bus.stall_MEM),
    .d      (wb_d),
    .q      (wb_q)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_sel(bus.rs_ID, i) != '0) begin
        if (ex_d.ld && rs_sel(bus.rs_ID, i) == ex_d.rd) hazard = 1'b1;
        if (mem_q.we && mem_q.ld && rs_sel(bus.rs_ID, i) == mem_q.rd) hazard = 1'b1;
      end
    end
  end

  assign bus.load_use_stall = hazard & ~rst;
  assign bus.rd_MEM         = mem_q.rd;
  assign bus.REG_write_MEM  = mem_q.we & ~mem_q.ld;
  assign bus.data_MEM       = mem_q.data;
  assign bus.rd_WB          = wb_q.rd;
  assign bus.REG_write_WB   = wb_q.we;
  assign bus.data_WB        = wb_q.data;
  assign unused_wb_ld       = wb_q.ld;

endmodule

// File: tb/tb_wb_dest_pipe.sv
// tb/tb_wb_dest_pipe.sv - directed self-checking bench for wb_dest_pipe
module tb_wb_dest_pipe;
  import wb_dest_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_dest_pipe_if bus ();

  wb_dest_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ex_idle();
    bus.rd_EX        = '0;
    bus.REG_write_EX = 1'b0;
    bus.MEM_read_EX  = 1'b0;
    bus.alu_res_EX   = '0;
    bus.flush_EX     = 1'b0;
  endtask

  task automatic ex_op(input logic [4:0] rd, input logic ld, input logic [31:0] res);
    bus.rd_EX        = rd;
    bus.REG_write_EX = 1'b1;
    bus.MEM_read_EX  = ld;
    bus.alu_res_EX   = res;
    bus.flush_EX     = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    ex_op(5'd5, 1'b1, 32'h55);
    bus.stall_MEM     = 1'b0;
    bus.mem_rdata_MEM = 32'h1234;
    bus.rs_ID         = {5'd5, 5'd5, 5'd5};
    tick();
    tick();
    chk("rst_rd_MEM", bus.rd_MEM, 0);
    chk("rst_we_MEM", bus.REG_write_MEM, 0);
    chk("rst_data_MEM", bus.data_MEM, 0);
    chk("rst_rd_WB", bus.rd_WB, 0);
    chk("rst_we_WB", bus.REG_write_WB, 0);
    chk("rst_data_WB", bus.data_WB, 0);
    chk("rst_stall", bus.load_use_stall, 0);

    rst         = 1'b0;
    bus.rs_ID   = '0;
    ex_op(5'd5, 1'b0, 32'h11);
    tick();
    chk("alu_rd_MEM", bus.rd_MEM, 5);
    chk("alu_we_MEM", bus.REG_write_MEM, 1);
    chk("alu_data_MEM", bus.data_MEM, 32'h11);
    chk("alu_we_WB_early", bus.REG_write_WB, 0);
    ex_idle();
    tick();
    chk("alu_we_WB", bus.REG_write_WB, 1);
    chk("alu_rd_WB", bus.rd_WB, 5);
    chk("alu_data_WB", bus.data_WB, 32'h11);

    ex_op(5'd0, 1'b0, 32'h22);
    tick();
    chk("rd0_we_MEM", bus.REG_write_MEM, 0);
    ex_idle();
    tick();
    chk("rd0_we_WB", bus.REG_write_WB, 0);

    ex_op(5'd0, 1'b1, 32'h0);
    #1;
    chk("rd0_load_no_stall", bus.load_use_stall, 0);

    ex_op(5'd7, 1'b1, 32'h77);
    bus.rs_ID = {5'd0, 5'd7, 5'd0};
    #1;
    chk("ld_stall_ex", bus.load_use_stall, 1);
    tick();
    ex_idle();
    #1;
    chk("ld_rd_MEM", bus.rd_MEM, 7);
    chk("ld_we_MEM", bus.REG_write_MEM, 0);
    chk("ld_stall_mem", bus.load_use_stall, 1);
    bus.mem_rdata_MEM = 32'hCAFE;
    tick();
    chk("ld_data_WB", bus.data_WB, 32'hCAFE);
    chk("ld_we_WB", bus.REG_write_WB, 1);
    chk("ld_rd_WB", bus.rd_WB, 7);
    chk("ld_stall_drop", bus.load_use_stall, 0);

    ex_op(5'd8, 1'b1, 32'h88);
    bus.rs_ID = {5'd8, 5'd0, 5'd0};
    #1;
    chk("sl_stall_ex", bus.load_use_stall, 1);
    tick();
    bus.stall_MEM     = 1'b1;
    bus.mem_rdata_MEM = 32'hDEAD;
    ex_op(5'd9, 1'b0, 32'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sl_rd_MEM_%0d", i), bus.rd_MEM, 8);
      chk($sformatf("sl_we_WB_%0d", i), bus.REG_write_WB, 0);
      chk($sformatf("sl_stall_%0d", i), bus.load_use_stall, 1);
    end
    bus.stall_MEM     = 1'b0;
    bus.mem_rdata_MEM = 32'hBEEF;
    ex_idle();
    tick();
    chk("sl_we_WB", bus.REG_write_WB, 1);
    chk("sl_data_WB", bus.data_WB, 32'hBEEF);
    chk("sl_rd_WB", bus.rd_WB, 8);
    chk("sl_stall_drop", bus.load_use_stall, 0);
    tick();
    chk("sl_single_write", bus.REG_write_WB, 0);

    bus.rs_ID = {5'd0, 5'd7, 5'd0};
    ex_op(5'd7, 1'b1, 32'h0);
    bus.flush_EX = 1'b1;
    #1;
    chk("fl_load_no_stall", bus.load_use_stall, 0);
    bus.rs_ID = '0;
    ex_op(5'd9, 1'b0, 32'h99);
    bus.flush_EX = 1'b1;
    tick();
    chk("fl_we_MEM", bus.REG_write_MEM, 0);
    ex_op(5'd4, 1'b0, 32'h44);
    tick();
    chk("fl_pre_rd_MEM", bus.rd_MEM, 4);
    bus.stall_MEM = 1'b1;
    ex_op(5'd9, 1'b0, 32'h99);
    bus.flush_EX = 1'b1;
    tick();
    chk("fs_rd_MEM", bus.rd_MEM, 4);
    chk("fs_we_MEM", bus.REG_write_MEM, 1);
    chk("fs_data_MEM", bus.data_MEM, 32'h44);
    bus.stall_MEM = 1'b0;
    ex_idle();
    tick();

    ex_op(5'd3, 1'b0, 32'hA);
    tick();
    ex_op(5'd3, 1'b0, 32'hB);
    tick();
    ex_idle();
    bus.rs_ID = {5'd3, 5'd0, 5'd3};
    #1;
    chk("fw_no_stall", bus.load_use_stall, 0);
    chk("fw_we_MEM", bus.REG_write_MEM, 1);
    chk("fw_we_WB", bus.REG_write_WB, 1);
    chk("fw_rd_MEM", bus.rd_MEM, 3);
    chk("fw_rd_WB", bus.rd_WB, 3);
    chk("fw_data_MEM", bus.data_MEM, 32'hB);
    chk("fw_data_WB", bus.data_WB, 32'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
